// File: rtl/burst_cache_pkg.sv
// burst_cache_pkg: shared types and line-geometry constants for burst_cache.
//   state_t      : miss-handling FSM states
//   LineBytes    : bytes per cache line
//   WordsPerLine : 32-bit words per line
//   BeatsPerLine : 64-bit RAM beats per line
//   OffsetBits   : byte-offset bits inside a line
package burst_cache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB      = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  localparam int LineBytes    = 32;
  localparam int WordsPerLine = 8;
  localparam int BeatsPerLine = 4;
  localparam int OffsetBits   = $clog2(LineBytes);

endpackage

// File: rtl/burst_cache_line_store.sv
// burst_cache_line_store: data/tag/valid/dirty storage for the cache lines.
//   clk, rst_n    : clock, async active-low reset (clears valid and dirty only)
//   i_idx         : line index shared by the read port and all write ports
//   o_valid/o_dirty/o_tag/o_line : combinational view of line i_idx
//   i_word_*      : byte-enabled client word write (marks the line dirty)
//   i_fill_*      : fill beat write, two words per beat
//   i_tag_we/i_tag: line completion (tag written, valid set, dirty cleared)
module burst_cache_line_store
  import burst_cache_pkg::*;
#(
  parameter int LineIndexBitWidth = 1,
  parameter int TagBitWidth       = 26
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LineIndexBitWidth-1:0]   i_idx,
  output logic                           o_valid,
  output logic                           o_dirty,
  output logic [TagBitWidth-1:0]         o_tag,
  output logic [WordsPerLine*32-1:0]     o_line,
  input  logic                           i_word_we,
  input  logic [2:0]                     i_word_sel,
  input  logic [3:0]                     i_byte_en,
  input  logic [31:0]                    i_word_data,
  input  logic                           i_fill_we,
  input  logic [1:0]                     i_fill_beat,
  input  logic [63:0]                    i_fill_data,
  input  logic                           i_tag_we,
  input  logic [TagBitWidth-1:0]         i_tag
);

  localparam int NumLines = 1 << LineIndexBitWidth;

  logic [31:0]            r_data [NumLines*WordsPerLine];
  logic [TagBitWidth-1:0] r_tag  [NumLines];
  logic [NumLines-1:0]    r_valid;
  logic [NumLines-1:0]    r_dirty;

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];

  for (genvar gi = 0; gi < WordsPerLine; gi++) begin : g_rd
    assign o_line[gi*32 +: 32] = r_data[{i_idx, 3'(gi)}];
  end

  // Data array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_word_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_en[b]) r_data[{i_idx, i_word_sel}][8*b +: 8] <= i_word_data[8*b +: 8];
      end
    end
    if (i_fill_we) begin
      r_data[{i_idx, i_fill_beat, 1'b0}] <= i_fill_data[31:0];
      r_data[{i_idx, i_fill_beat, 1'b1}] <= i_fill_data[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_idx] <= i_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_word_we) r_dirty[i_idx] <= 1'b1;
      if (i_tag_we) begin
        r_valid[i_idx] <= 1'b1;
        r_dirty[i_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/burst_cache.sv
// burst_cache: direct-mapped write-back write-allocate cache, 32-bit client
// side, 64-bit 4-beat burst RAM side.
//   clk, rst_n                         : clock, async active-low reset
//   enable/address/data_in/write_enable: client request (write_enable==0 reads)
//   data_out/data_out_ready/busy       : client response (busy while a miss runs)
//   br_cmd/br_cmd_en/br_addr           : burst command (0 read, 1 write)
//   br_wr_data/br_data_mask            : write beats, mask fixed to all bytes
//   br_rd_data/br_rd_data_valid        : read beats from the RAM
module burst_cache
  import burst_cache_pkg::*;
#(
  parameter int LineIndexBitWidth  = 1,
  parameter int RamAddressBitWidth = 10,
  parameter int RamAddressingMode  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [31:0]                   address,
  input  logic [31:0]                   data_in,
  input  logic [3:0]                    write_enable,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
);

  localparam int L    = LineIndexBitWidth;
  localparam int TagW = 32 - OffsetBits - L;

  state_t                          r_state;
  logic [$clog2(BeatsPerLine)-1:0] r_beat;
  logic [TagW-1:0]                 r_tag;
  logic [L-1:0]                    r_idx;
  logic                            r_br_cmd;
  logic                            r_br_cmd_en;
  logic [RamAddressBitWidth-1:0]   r_br_addr;
  logic [63:0]                     r_br_wr_data;

  logic [L-1:0]                    w_a_idx;
  logic [TagW-1:0]                 w_a_tag;
  logic [2:0]                      w_a_word;
  logic [L-1:0]                    w_idx;
  logic                            w_valid;
  logic                            w_dirty;
  logic [TagW-1:0]                 w_tag;
  logic [WordsPerLine*32-1:0]      w_line;
  logic                            w_hit;
  logic                            w_word_we;
  logic                            w_fill_we;
  logic                            w_tag_we;
  logic [1:0]                      w_next_beat;
  logic                            w_unused_addr_bits;

  assign w_a_word = address[4:2];
  assign w_a_idx  = address[OffsetBits +: L];
  assign w_a_tag  = address[31 -: TagW];
  assign w_unused_addr_bits = ^address[1:0];

  // Outside IDLE the store is addressed by the line latched at the miss.
  assign w_idx = (r_state == IDLE) ? w_a_idx : r_idx;

  burst_cache_line_store #(
    .LineIndexBitWidth(L),
    .TagBitWidth      (TagW)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_idx      (w_idx),
    .o_valid    (w_valid),
    .o_dirty    (w_dirty),
    .o_tag      (w_tag),
    .o_line     (w_line),
    .i_word_we  (w_word_we),
    .i_word_sel (w_a_word),
    .i_byte_en  (write_enable),
    .i_word_data(data_in),
    .i_fill_we  (w_fill_we),
    .i_fill_beat(r_beat),
    .i_fill_data(br_rd_data),
    .i_tag_we   (w_tag_we),
    .i_tag      (r_tag)
  );

  function automatic logic [RamAddressBitWidth-1:0] ram_addr(input logic [31:0] byte_addr);
    logic [31:0] shifted;
    shifted = byte_addr >> RamAddressingMode;
    return shifted[RamAddressBitWidth-1:0];
  endfunction

  assign w_hit       = enable && w_valid && (w_tag == w_a_tag);
  assign w_word_we   = (r_state == IDLE) && w_hit && (|write_enable);
  assign w_fill_we   = (r_state == RD_WAIT) && br_rd_data_valid;
  assign w_tag_we    = w_fill_we && (r_beat == 2'd3);
  assign w_next_beat = r_beat + 2'd1;

  // Client outputs are held inactive while reset is asserted.
  assign data_out       = w_line[{w_a_word, 5'b0} +: 32];
  assign data_out_ready = rst_n && (r_state == IDLE) && w_hit;
  assign busy           = rst_n && ((r_state != IDLE) || (enable && !w_hit));

  assign br_cmd       = r_br_cmd;
  assign br_cmd_en    = r_br_cmd_en;
  assign br_addr      = r_br_addr;
  assign br_wr_data   = r_br_wr_data;
  assign br_data_mask = 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_beat       <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_br_cmd     <= 1'b0;
      r_br_cmd_en  <= 1'b0;
      r_br_addr    <= '0;
      r_br_wr_data <= '0;
    end else begin
      r_br_cmd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (enable && !w_hit) begin
            r_tag       <= w_a_tag;
            r_idx       <= w_a_idx;
            r_beat      <= '0;
            r_br_cmd_en <= 1'b1;
            if (w_valid && w_dirty) begin
              // Evict: beat 0 goes out together with the write command.
              r_state      <= WB;
              r_br_cmd     <= 1'b1;
              r_br_addr    <= ram_addr({w_tag, w_a_idx, {OffsetBits{1'b0}}});
              r_br_wr_data <= w_line[63:0];
            end else begin
              r_state   <= RD_CMD;
              r_br_cmd  <= 1'b0;
              r_br_addr <= ram_addr({w_a_tag, w_a_idx, {OffsetBits{1'b0}}});
            end
          end
        end
        WB: begin
          if (r_beat == 2'd3) begin
            r_state     <= RD_CMD;
            r_beat      <= '0;
            r_br_cmd    <= 1'b0;
            r_br_cmd_en <= 1'b1;
            r_br_addr   <= ram_addr({r_tag, r_idx, {OffsetBits{1'b0}}});
          end else begin
            r_beat       <= w_next_beat;
            r_br_wr_data <= w_line[{w_next_beat, 6'b0} +: 64];
          end
        end
        RD_CMD: begin
          r_state <= RD_WAIT;
          r_beat  <= '0;
        end
        RD_WAIT: begin
          if (br_rd_data_valid) begin
            r_beat <= w_next_beat;
            if (r_beat == 2'd3) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_cache.sv
module tb_burst_cache;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [9:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;

  burst_cache #(
    .LineIndexBitWidth (1),
    .RamAddressBitWidth(10),
    .RamAddressingMode (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .address         (address),
    .data_in         (data_in),
    .write_enable    (write_enable),
    .data_out        (data_out),
    .data_out_ready  (data_out_ready),
    .busy            (busy),
    .br_cmd          (br_cmd),
    .br_cmd_en       (br_cmd_en),
    .br_addr         (br_addr),
    .br_wr_data      (br_wr_data),
    .br_data_mask    (br_data_mask),
    .br_rd_data      (br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Burst RAM model: double-word addressed, word content = its byte address.
  logic [63:0] ram [0:1023];
  bit          ram_init = 0;
  int          latency  = 0;
  int          gap      = 0;
  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  logic [9:0]  last_rd_addr = '0;
  logic [9:0]  last_wr_addr = '0;
  bit          rd_active = 0;
  int          rd_delay  = 0;
  int          rd_beat   = 0;
  logic [9:0]  rd_addr   = '0;
  logic [9:0]  wr_addr   = '0;
  int          wr_left   = 0;

  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] = {32'(i*8 + 4), 32'(i*8)};
      ram_init = 1;
    end
    br_rd_data_valid = 1'b0;
    br_rd_data       = 64'h0;
    if (!rst_n) begin
      rd_active = 0;
      wr_left   = 0;
    end else begin
      if (wr_left > 0) begin
        ram[wr_addr] = br_wr_data;
        wr_addr      = wr_addr + 10'd1;
        wr_left--;
      end
      if (br_cmd_en) begin
        if (br_cmd) begin
          ram[br_addr] = br_wr_data;
          wr_addr      = br_addr + 10'd1;
          wr_left      = 3;
          wr_cnt++;
          last_wr_addr = br_addr;
        end else begin
          rd_active    = 1;
          rd_addr      = br_addr;
          rd_beat      = 0;
          rd_delay     = latency;
          rd_cnt++;
          last_rd_addr = br_addr;
        end
      end else if (rd_active) begin
        if (rd_delay > 0) begin
          rd_delay--;
        end else begin
          br_rd_data_valid = 1'b1;
          br_rd_data       = ram[rd_addr + 10'(rd_beat)];
          rd_beat++;
          rd_delay = gap;
          if (rd_beat == 4) rd_active = 0;
        end
      end
    end
  end

  // Drive one request from a negedge, wait for busy to drop, capture the
  // response, then pass one posedge (where a write hit commits).
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                        output logic [31:0] dout, output logic rdy, output int cyc);
    enable       = 1'b1;
    address      = a;
    data_in      = d;
    write_enable = we;
    cyc          = 0;
    #1;
    while (busy === 1'b1 && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    dout = data_out;
    rdy  = data_out_ready;
    $display("[TB] access addr=%h we=%b data_in=%h -> data_out=%h ready=%b cycles=%0d",
             a, we, d, dout, rdy, cyc);
    @(negedge clk);
    enable       = 1'b0;
    write_enable = 4'b0;
  endtask

  logic [31:0] dout;
  logic        rdy;
  int          cyc;
  int          rd_before;
  int          wr_before;

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    address      = 32'h0;
    data_in      = 32'h0;
    write_enable = 4'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy",    64'(busy),           64'd0);
    chk("rst_ready",   64'(data_out_ready), 64'd0);
    chk("rst_cmd_en",  64'(br_cmd_en),      64'd0);
    chk("rst_cmd",     64'(br_cmd),         64'd0);
    chk("rst_addr",    64'(br_addr),        64'd0);
    chk("rst_wr_data", br_wr_data,          64'd0);
    chk("data_mask",   64'(br_data_mask),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold read miss
    access(32'h40, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("cold_busy_seen", 64'(cyc > 0 && cyc < 300), 64'd1);
    chk("cold_data",      64'(dout),         64'h40);
    chk("cold_ready",     64'(rdy),          64'd1);
    chk("cold_rd_addr",   64'(last_rd_addr), 64'd8);
    chk("cold_rd_cnt",    64'(rd_cnt),       64'd1);
    chk("cold_wr_cnt",    64'(wr_cnt),       64'd0);

    // Write hit: old word visible in the write cycle
    access(32'h44, 32'hAABBCCDD, 4'b0100, dout, rdy, cyc);
    chk("wr_hit_cycles", 64'(cyc),  64'd0);
    chk("wr_old_data",   64'(dout), 64'h44);
    access(32'h44, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("wr_readback",   64'(dout), 64'h00BB0044);
    chk("wr_rb_ready",   64'(rdy),  64'd1);

    // Conflicting read evicts the dirty line
    access(32'h80, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("evict_data",    64'(dout),         64'h80);
    chk("evict_wr_cnt",  64'(wr_cnt),       64'd1);
    chk("evict_wr_addr", 64'(last_wr_addr), 64'd8);
    chk("evict_beat0",   ram[8],            64'h00BB0044_00000040);
    chk("evict_beat1",   ram[9],            64'h0000004C_00000048);
    chk("evict_beat3",   ram[11],           64'h0000005C_00000058);
    chk("evict_rd_addr", 64'(last_rd_addr), 64'd16);
    chk("evict_rd_cnt",  64'(rd_cnt),       64'd3 - 64'd1);

    // Re-read 0x44: clean victim, no writeback
    access(32'h44, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("reread_data",    64'(dout),         64'h00BB0044);
    chk("reread_wr_cnt",  64'(wr_cnt),       64'd1);
    chk("reread_rd_addr", 64'(last_rd_addr), 64'd8);

    // Long latency with gaps between beats
    latency = 20;
    gap     = 1;
    access(32'hC0, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("lat20_data",    64'(dout),         64'hC0);
    chk("lat20_rd_addr", 64'(last_rd_addr), 64'd24);
    chk("lat20_busy",    64'(cyc > 24 && cyc < 300), 64'd1);
    access(32'hD8, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("lat20_hit_w6",  64'(dout), 64'hD8);
    access(32'h2C, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("idx1_data",     64'(dout),         64'h2C);
    chk("idx1_rd_addr",  64'(last_rd_addr), 64'd4);

    // Reset in RD_WAIT aborts the fill and invalidates every line
    enable       = 1'b1;
    address      = 32'h100;
    write_enable = 4'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy",   64'(busy),           64'd0);
    chk("abort_ready",  64'(data_out_ready), 64'd0);
    chk("abort_cmd_en", 64'(br_cmd_en),      64'd0);
    $display("[TB] reset asserted during RD_WAIT: busy=%b", busy);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    latency = 0;
    gap     = 0;
    @(negedge clk);
    rd_before = rd_cnt;
    wr_before = wr_cnt;
    access(32'h100, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("post_rst_data",    64'(dout),         64'h100);
    chk("post_rst_rd_cnt",  64'(rd_cnt),       64'(rd_before + 1));
    chk("post_rst_rd_addr", 64'(last_rd_addr), 64'd32);
    rd_before = rd_cnt;
    access(32'h24, 32'h0, 4'b0000, dout, rdy, cyc);
    chk("post_rst_idx1_miss", 64'(rd_cnt),  64'(rd_before + 1));
    chk("post_rst_idx1_data", 64'(dout),    64'h24);
    chk("post_rst_no_wb",     64'(wr_cnt),  64'(wr_before));

    // Idle with enable low
    address = 32'h24;
    #1;
    chk("idle_busy",  64'(busy),           64'd0);
    chk("idle_ready", 64'(data_out_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_cache.md
Name: burst_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between a 32-bit word client and a 64-bit burst RAM controller (PSRAM-style).
- Cache lines are 32 B (8 words, 4 RAM beats); capacity is 2^LineIndexBitWidth lines.
- Sits under the RAM/I-O front end, which feeds it 4-byte-aligned addresses and byte-enabled word writes.

Parameters:
- LineIndexBitWidth, 1: number of lines = 2^value; cache size = 2^value*32 B.
- RamAddressBitWidth, 10: width of br_addr.
- RamAddressingMode, 3: unit of br_addr; 0 byte, 1 half word, 2 word, 3 double word. br_addr = line byte address >> value, truncated to RamAddressBitWidth.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  client request valid.
- address  in  32  byte address, 4-byte aligned.
- data_in  in  32  write data, lanes already positioned.
- write_enable  in  4  byte enables; 0 means read.
- data_out  out  32  word at address.
- data_out_ready  out  1  data_out valid (hit).
- busy  out  1  miss being serviced.
- br_cmd  out  1  0 read, 1 write.
- br_cmd_en  out  1  one-cycle command strobe.
- br_addr  out  RamAddressBitWidth  burst start address.
- br_wr_data  out  64  write beat.
- br_data_mask  out  8  constant 0 (write all bytes).
- br_rd_data  in  64  read beat.
- br_rd_data_valid  in  1  read beat valid.

Behaviour:
- Address split: [4:2] word-in-line, [5+L-1:5] line index, [31:5+L] tag (L = LineIndexBitWidth).
- Per line: valid bit, dirty bit, tag, 8 x 32-bit data.
- Reset (async): all valid/dirty = 0, FSM = IDLE. Outputs: busy = 0, data_out_ready = 0, br_cmd_en = 0, br_cmd = 0, br_addr = 0, br_wr_data = 0. Data array is not reset.
- hit = enable & valid[idx] & tag match. Combinational in IDLE:
  - data_out = stored word.
  - data_out_ready = hit.
  - busy = enable & !hit.
- Write hit: at the clock edge, each enabled byte is written and the line is marked dirty. data_out shows the old word in that cycle. A write is complete when busy is 0.
- FSM states IDLE, WB, RD_CMD, RD_WAIT. In every state other than IDLE: busy = 1, data_out_ready = 0.
- IDLE, miss, line dirty -> WB:
  - Cycle 0: br_cmd = 1, br_cmd_en = 1, br_addr = evicted line address (old tag:idx:00000), br_wr_data = beat 0.
  - Beats 1..3 on the following 3 cycles, with br_cmd_en = 0.
  - Beat k = {word 2k+1, word 2k}.
  - Then go to RD_CMD.
- IDLE, miss, line clean or invalid -> RD_CMD.
- RD_CMD: one cycle with br_cmd = 0, br_cmd_en = 1, br_addr = requested line address. Then go to RD_WAIT.
- RD_WAIT:
  - Latency is unbounded.
  - Each cycle with br_rd_data_valid = 1 stores beat k (k = 0..3): low 32 bits into word 2k, high 32 bits into word 2k+1.
  - After beat 3: tag written, valid = 1, dirty = 0, go to IDLE.
  - The next cycle is a hit and serves the pending read or write.
- Miss handling starts from the address latched at the miss. Changes to enable or address mid-miss do not alter the fill.
- br_cmd_en is never asserted outside the two command cycles above.
- Reset during WB or RD_WAIT aborts the burst and invalidates all lines. The RAM model must tolerate the abandoned burst.
- enable = 0: busy = 0, data_out_ready = 0, no state change in IDLE.

Decomposition:
- Package burst_cache_pkg:
  - state enum {IDLE, WB, RD_CMD, RD_WAIT}.
  - Constants: LineBytes = 32, WordsPerLine = 8, BeatsPerLine = 4, OffsetBits = 5.
- One sub-module, burst_cache_line_store: byte-enabled word RAM plus tag/valid/dirty arrays. It has one combinational read port and one synchronous write port (client byte write or fill beat of 2 words).

Test Plan:
- Cold read 0x0000_0040 with RAM pattern word = byte address -> busy = 1, then RD_CMD with br_addr = 0x40 >> 3 = 8 and br_cmd = 0. After 4 beats, data_out = 0x40 with data_out_ready = 1 and busy = 0.
- Write 0xAABBCCDD, we = 4'b0100, to 0x44 (a hit) -> next read of 0x44 returns 0x00BB0044; the line is dirty.
- Conflicting read 0x0000_0080 (same index, L = 1) -> write burst at br_addr 8 with beats {0x00BB0044,0x40}, {0x4C,0x48}, ... Then read command at br_addr 16, and data_out = 0x80.
- Re-read 0x44 -> writeback of the 0x80 line skipped (clean). Refill returns 0x00BB0044 from RAM.
- Read-data latency of 0 and 20 cycles with gaps between valid beats -> identical results; busy held throughout.
- Assert rst_n low during RD_WAIT -> busy = 0 immediately. A subsequent access to the same address misses and issues a fresh RD_CMD.
